exec_unit: RTL
==============

# exec_unit

Execution stage directly downstream of the 8×8 register file. It latches the two read-port operands and an opcode, then computes single-cycle logic/arithmetic or iterative multiply/shift results. It drives the register file write port (data, address, write enable) for exactly one cycle per completed operation. Clock and reset naming, 8-bit data and 3-bit register addresses match the register file.

## Interface
Parameters:
- DW, 8, datapath width; only 8 is supported.
- AW, 3, register address width.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only when the unit is ready (state IDLE or DONE).
- OPCODE  in  3  000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL, 101 SLL, 110 SRL, 111 SRA.
- DATA1  in  8  operand A (register file OUT1DATA).
- DATA2  in  8  operand B / shift amount (register file OUT2DATA).
- DEST  in  3  destination register address.
- BUSY  out  1  high when state is RUN.
- RESULT  out  8  result, to register file INDATA.
- WRADDR  out  3  to register file INADDRESS.
- WRITE  out  1  to register file WRITE; one-cycle pulse.
- ZERO  out  1  registered RESULT==0, valid while WRITE is high.
- ERR  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- FSM states:
  - IDLE: START → RUN if the op is MUL or a shift with nonzero count; otherwise → DONE.
  - RUN: counts iterations; when the last iteration finishes → DONE.
  - DONE: WRITE=1. START accepted → same transitions as IDLE; otherwise → IDLE.
- On acceptance, latch OPCODE, DATA1, DATA2 and DEST. Input changes after that have no effect.
- FWD: RESULT=DATA2. ADD: DATA1+DATA2 mod 256, carry dropped. AND/OR: bitwise.
- MUL: unsigned shift-add over 8 RUN cycles, one multiplier bit per cycle. RESULT = low 8 bits of the product.
- Shifts: DATA1 is shifted by count n. n = DATA2[2:0] when DATA2[7:3]==0; otherwise n = 8 (saturated). One bit per RUN cycle.
  - n=0 goes straight to DONE with RESULT=DATA1.
  - SLL/SRL with n=8 gives 0x00. SRA with n=8 gives 0x00 or 0xFF according to DATA1[7].
- START while BUSY is ignored. There is no queueing.
- RESET at any state (including mid-RUN) → IDLE next edge with no write. The partial result is discarded.

## Timing
- Reset values: BUSY 0, WRITE 0, ERR 0, RESULT 0x00, WRADDR 0, ZERO 0, state IDLE.
- Single-cycle ops: START accepted at edge N; RESULT/WRADDR/ZERO/WRITE valid after edge N+1. The register file captures at edge N+2.
- MUL: accepted at edge N; RUN for edges N+1..N+8; DONE (WRITE=1) after edge N+9. Latency 9 cycles.
- Shift by n≥1: DONE after edge N+n+1.
- RESULT and WRADDR hold their last values outside DONE. WRITE is high only in DONE.
- Back-to-back single-cycle ops with START held high give one write per cycle.

## Configuration
- EXEC_MUL_EN defined: MUL implemented as above.
- EXEC_MUL_EN undefined: opcode 100 goes IDLE→DONE with WRITE=0 and ERR=1 for that DONE cycle. RESULT and WRADDR are unchanged. No multiplier logic is synthesized.

## Structure
- Shared package exec_pkg holds:
  - opcode constants (OP_FWD … OP_SRA);
  - FSM state encoding (S_IDLE, S_RUN, S_DONE);
  - the MUL iteration count (8).
- Sub-module seq_mul8 is the iterative shift-add multiplier. It has load/step inputs and exposes the 8-bit partial product. It is instantiated only under EXEC_MUL_EN.
- Shift and single-cycle logic stay in exec_unit.

## Test plan
- Reset then ADD DATA1=0xF0, DATA2=0x20, DEST=5 → after two edges RESULT=0x10, WRADDR=5, WRITE high for one cycle, ZERO=0.
- MUL 0x0D×0x0B (EXEC_MUL_EN) → BUSY high for 8 cycles, then RESULT=0x8F with a single WRITE pulse. START pulses during BUSY cause no extra write.
- Shifts:
  - SRA 0x90 by DATA2=0x02 → RESULT=0xE4 after 3 cycles.
  - SRA 0x90 by DATA2=0x40 → RESULT=0xFF.
  - SLL 0x81 by 0x00 → RESULT=0x81, no RUN cycles.
- RESET asserted at the 4th RUN cycle of a MUL → WRITE stays 0, next cycle state is IDLE, and all outputs are at reset values.
- Back-to-back FWD 0x00 then OR 0x0F|0xF0 with START held high → consecutive WRITE cycles giving RESULT 0x00 (ZERO=1) then 0xFF (ZERO=0).
- EXEC_MUL_EN undefined: MUL request → ERR pulse, WRITE=0, RESULT unchanged.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execution stage: opcode encoding, FSM states and
// the multiplier iteration count.
package exec_pkg;

  localparam int MUL_ITERS = 8;

  typedef enum logic [2:0] {
    OP_FWD = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  // Shift counts above 7 saturate to a full-width shift.
  function automatic logic [3:0] shift_count(input logic [7:0] amount);
    return (amount[7:3] == 5'd0) ? {1'b0, amount[2:0]} : 4'd8;
  endfunction

endpackage

// File: rtl/exec_unit_mul.sv
// seq_mul8: iterative 8x8 shift-add multiplier keeping only the low product
// byte; one multiplier bit is consumed per step.
module seq_mul8 (
  input  logic       CLK,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] partial
);

  logic [7:0] acc_q;
  logic [7:0] mcand_q;
  logic [7:0] mplier_q;

  // Partial product after the step currently being taken.
  assign partial = acc_q + (mplier_q[0] ? mcand_q : 8'h00);

  // NOTE: pure datapath registers that are always loaded before use, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (load) begin
      acc_q    <= 8'h00;
      mcand_q  <= a;
      mplier_q <= b;
    end else if (step) begin
      acc_q    <= partial;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execution stage feeding the register file write port. Define EXEC_MUL_EN to
// build the iterative multiplier; otherwise opcode MUL raises ERR.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [2:0]    OPCODE,
  input  logic [DW-1:0] DATA1,
  input  logic [DW-1:0] DATA2,
  input  logic [AW-1:0] DEST,
  output logic          BUSY,
  output logic [DW-1:0] RESULT,
  output logic [AW-1:0] WRADDR,
  output logic          WRITE,
  output logic          ZERO,
  output logic          ERR
);

  state_e        state;
  opcode_e       op_q;
  logic [AW-1:0] dest_q;
  logic [DW-1:0] sh_q;
  logic [3:0]    cnt_q;
  logic [3:0]    last_q;

  opcode_e       op_in;
  logic [3:0]    n_in;
  logic          is_shift_in;
  logic          is_mul_in;
  logic [DW-1:0] quick_res;
  logic [DW-1:0] sh_next;
  logic [DW-1:0] run_res;
  logic [DW-1:0] mul_next;

  assign op_in       = opcode_e'(OPCODE);
  assign n_in        = shift_count(DATA2);
  assign is_shift_in = op_in inside {OP_SLL, OP_SRL, OP_SRA};
  assign is_mul_in   = (op_in == OP_MUL);

`ifdef EXEC_MUL_EN
  seq_mul8 u_mul (
    .CLK     (CLK),
    .load    (START && (state != S_RUN) && is_mul_in),
    .step    ((state == S_RUN) && (op_q == OP_MUL)),
    .a       (DATA1),
    .b       (DATA2),
    .partial (mul_next)
  );
`else
  assign mul_next = '0;
`endif

  // Ops that finish on the accepting edge; a zero-count shift forwards DATA1.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    quick_res = DATA1;
    case (op_in)
      OP_FWD:  quick_res = DATA2;
      OP_ADD:  quick_res = DATA1 + DATA2;
      OP_AND:  quick_res = DATA1 & DATA2;
      OP_OR:   quick_res = DATA1 | DATA2;
      default: quick_res = DATA1;
    endcase
  end

  always_comb begin
    sh_next = {sh_q[DW-1], sh_q[DW-1:1]};
    case (op_q)
      OP_SLL:  sh_next = sh_q << 1;
      OP_SRL:  sh_next = sh_q >> 1;
      default: sh_next = {sh_q[DW-1], sh_q[DW-1:1]};
    endcase
    run_res = (op_q == OP_MUL) ? mul_next : sh_next;
  end

  // NOTE: state and registered outputs use non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      op_q   <= OP_FWD;
      dest_q <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      BUSY   <= 1'b0;
      RESULT <= '0;
      WRADDR <= '0;
      WRITE  <= 1'b0;
      ZERO   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      WRITE <= 1'b0;
      ERR   <= 1'b0;
      case (state)
        S_RUN: begin
          sh_q  <= sh_next;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == last_q) begin
            state  <= S_DONE;
            BUSY   <= 1'b0;
            WRITE  <= 1'b1;
            WRADDR <= dest_q;
            RESULT <= run_res;
            ZERO   <= (run_res == '0);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (START) begin
            op_q   <= op_in;
            dest_q <= DEST;
            sh_q   <= DATA1;
            cnt_q  <= 4'd0;
            if (is_mul_in) begin
`ifdef EXEC_MUL_EN
              state  <= S_RUN;
              BUSY   <= 1'b1;
              last_q <= 4'(MUL_ITERS - 1);
`else
              state <= S_DONE;
              ERR   <= 1'b1;
`endif
            end else if (is_shift_in && (n_in != 4'd0)) begin
              state  <= S_RUN;
              BUSY   <= 1'b1;
              last_q <= n_in - 4'd1;
            end else begin
              state  <= S_DONE;
              WRITE  <= 1'b1;
              WRADDR <= DEST;
              RESULT <= quick_res;
              ZERO   <= (quick_res == '0);
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
